// File: rtl/apb_arb_pkg.sv
// Shared types for the APB master arbiter.
// State enum, requester limit, index-width helper.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_arb_state_t;

  localparam int MAX_REQ = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_bus_if.sv
// APB bus bundle between master and slave side.
// Master drives clock/reset and request fields.
interface ApbBus #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 PCLK;
  logic                 PRESETn;
  logic [AddrWidth-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [DataWidth-1:0] PWDATA;
  logic [DataWidth-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERROR;

  modport Master (
    output PCLK, PRESETn,
    output PADDR, PSEL, PENABLE,
    output PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERROR
  );

  modport Slave (
    input  PCLK, PRESETn,
    input  PADDR, PSEL, PENABLE,
    input  PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERROR
  );
endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin picker.
// In: req, ptr. Out: one-hot gnt, idx, any.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] hi;
  logic [N-1:0] pick;

  // Requests at or above ptr win; else wrap to the lowest.
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) begin
      hi[i] = (i >= int'(ptr));
    end
    pick = (|(req & hi)) ? (req & hi) : req;
    idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) idx = IW'(i);
    end
    any      = |req;
    gnt      = '0;
    gnt[idx] = any;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NumReq req/done ports, round-robin granted.
// Optional ACCESS timeout when APB_TIMEOUT_EN is defined.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic [NumReq-1:0]                 req,
  input  logic [NumReq-1:0]                 we,
  input  logic [NumReq-1:0][AddrWidth-1:0]  addr,
  input  logic [NumReq-1:0][DataWidth-1:0]  wdata,
  output logic [NumReq-1:0]                 done,
  output logic [DataWidth-1:0]              rdata,
  output logic                              err,
  ApbBus.Master                             bus
);

  localparam int IW = idx_w(NumReq);

  if (NumReq < 2 || NumReq > MAX_REQ ||
      TimeoutCycles < 1) begin : g_bad_param
    $error("apb_master_arbiter: bad parameter");
  end

  apb_arb_state_t state, state_n;

  logic [NumReq-1:0]    elig;
  logic [NumReq-1:0]    gnt;
  logic [NumReq-1:0]    gsel;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        ptr;
  logic                 any;
  logic                 timeout;
  logic [AddrWidth-1:0] paddr;
  logic [DataWidth-1:0] pwdata;
  logic                 pwrite;

  // Masking done keeps a finisher out of its own done cycle.
  assign elig = req & ~done;

  rr_arbiter #(
    .N  (NumReq),
    .IW (IW)
  ) u_rr (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign bus.PCLK    = PCLK;
  assign bus.PRESETn = PRESETn;
  assign bus.PADDR   = paddr;
  assign bus.PWRITE  = pwrite;
  assign bus.PWDATA  = pwdata;
  assign bus.PSEL    = (state != IDLE);
  assign bus.PENABLE = (state == ACCESS);

`ifdef APB_TIMEOUT_EN
  localparam int CW0 = $clog2(TimeoutCycles + 1);
  localparam int CW  = (CW0 < 8) ? 8 :
                       (CW0 > 16) ? 16 : CW0;

  logic [CW-1:0] cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
    end
  end

  // PREADY in the limit cycle wins over the timeout.
  assign timeout = (state == ACCESS) && !bus.PREADY &&
                   (cnt == CW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any) state_n = SETUP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (bus.PREADY || timeout)
                 state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= IDLE;
      gsel   <= '0;
      ptr    <= '0;
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      done   <= '0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= '0;
      if (state == IDLE && any) begin
        gsel   <= gnt;
        ptr    <= (gidx == IW'(NumReq - 1)) ?
                  '0 : gidx + 1'b1;
        paddr  <= addr[gidx];
        pwrite <= we[gidx];
        pwdata <= wdata[gidx];
      end
      if (state == ACCESS) begin
        if (bus.PREADY) begin
          done  <= gsel;
          rdata <= pwrite ? '0 : bus.PRDATA;
          err   <= bus.PSLVERROR;
        end else if (timeout) begin
          done  <= gsel;
          rdata <= '0;
          err   <= 1'b1;
        end
      end
    end
  end

endmodule
